// File: rtl/wb_picc_host.sv
// wb_picc_host: Wishbone B2 initiator that programs the 8-line PIC and sequences its interrupts to the CPU.
// Optional feature macro IRQ_NEST_EN: priority stack for nested interrupt service (depth 0..7).
module wb_picc_host #(
   parameter logic [7:0] INIT_MASK   = 8'hFF,
   parameter logic [2:0] INIT_PRI    = 3'd0,
   parameter int         ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   output logic       wb_sel_o,
   output logic [7:0] wb_addr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_ack_i,
   input  logic       wb_irq,
   output logic       vec_valid,
   output logic [2:0] vec,
   input  logic       vec_ready,
   input  logic       eoi,
   input  logic       mask_req,
   input  logic [7:0] mask_val,
   output logic       mask_gnt,
   output logic [3:0] depth,
   output logic       init_done,
   output logic       err
);

   typedef enum logic [3:0] {
      S_INIT_MASK, S_INIT_PRI, S_IDLE, S_RD_IRQ, S_WR_PRI,
      S_DELIVER, S_EOI_WR, S_MASK_WR, S_GAP
   } state_t;

   state_t     r_state, w_stateN, r_after, w_afterN;
   logic       r_bus, w_busN, r_we, w_weN;
   logic [7:0] r_addr, w_addrN, r_dat, w_datN, r_tmo, w_tmoN;
   logic [2:0] r_vec, w_vecN, r_curPri, w_curPriN;
   logic [3:0] r_depth, w_depthN;
   logic       r_maskGnt, w_maskGntN, r_initDone, w_initDoneN;
   logic       r_err, w_errN, r_eoiPend, w_eoiPendN;
   logic       w_ack, w_tmoHit, w_eoiReq, w_irqOk;
   logic       w_start, w_startWe;
   logic [7:0] w_startAddr, w_startDat;
   logic [2:0] w_popVal, w_priVal;
   logic       w_unusedDatHi;

   assign w_unusedDatHi = ^wb_dat_i[7:3];
   assign w_ack         = r_bus && wb_ack_i;
   assign w_tmoHit      = r_bus && !wb_ack_i && (r_tmo == 8'(ACK_TIMEOUT - 1));
   assign w_eoiReq      = eoi || r_eoiPend;

`ifdef IRQ_NEST_EN
   logic       w_push;
   logic [2:0] r_stack [0:7];

   // The stack pointer is the nesting depth itself; cur_pri only ever rises on push, so it never overflows.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) r_stack[i] <= 3'd0;
      end else if (w_push) begin
         r_stack[r_depth[2:0]] <= r_curPri;
      end
   end

   assign w_popVal = r_stack[r_depth[2:0] - 3'd1];
   assign w_priVal = r_vec;
   assign w_irqOk  = 1'b1;
`else
   assign w_popVal = INIT_PRI;
   assign w_priVal = 3'd7;
   assign w_irqOk  = (r_depth == 4'd0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_INIT_MASK;
         r_after    <= S_IDLE;
         r_bus      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= 8'd0;
         r_dat      <= 8'd0;
         r_tmo      <= 8'd0;
         r_vec      <= 3'd0;
         r_curPri   <= INIT_PRI;
         r_depth    <= 4'd0;
         r_maskGnt  <= 1'b0;
         r_initDone <= 1'b0;
         r_err      <= 1'b0;
         r_eoiPend  <= 1'b0;
      end else begin
         r_state    <= w_stateN;
         r_after    <= w_afterN;
         r_bus      <= w_busN;
         r_we       <= w_weN;
         r_addr     <= w_addrN;
         r_dat      <= w_datN;
         r_tmo      <= w_tmoN;
         r_vec      <= w_vecN;
         r_curPri   <= w_curPriN;
         r_depth    <= w_depthN;
         r_maskGnt  <= w_maskGntN;
         r_initDone <= w_initDoneN;
         r_err      <= w_errN;
         r_eoiPend  <= w_eoiPendN;
      end
   end

   always_comb begin
      w_stateN    = r_state;
      w_afterN    = r_after;
      w_busN      = r_bus;
      w_weN       = r_we;
      w_addrN     = r_addr;
      w_datN      = r_dat;
      w_tmoN      = r_tmo;
      w_vecN      = r_vec;
      w_curPriN   = r_curPri;
      w_depthN    = r_depth;
      w_maskGntN  = 1'b0;
      w_initDoneN = r_initDone;
      w_errN      = r_err;
      w_eoiPendN  = r_eoiPend;
      w_start     = 1'b0;
      w_startWe   = 1'b0;
      w_startAddr = 8'd0;
      w_startDat  = 8'd0;
`ifdef IRQ_NEST_EN
      w_push      = 1'b0;
`endif

      if (eoi && r_state != S_IDLE) w_eoiPendN = 1'b1;

      // Any transfer ends on ack or timeout; the GAP cycle keeps the trailing registered ack away from the next strobe.
      if (r_bus) begin
         if (w_ack || w_tmoHit) begin
            w_busN   = 1'b0;
            w_weN    = 1'b0;
            w_stateN = S_GAP;
            w_afterN = S_IDLE;
            if (w_tmoHit) w_errN = 1'b1;
         end else begin
            w_tmoN = r_tmo + 8'd1;
         end
      end

      case (r_state)
         S_INIT_MASK: begin
            if (!r_bus) begin
               w_start     = 1'b1;
               w_startWe   = 1'b1;
               w_startAddr = 8'd0;
               w_startDat  = INIT_MASK;
            end else if (w_ack || w_tmoHit) begin
               w_afterN = S_INIT_PRI;
            end
         end
         S_INIT_PRI: begin
            if (w_ack || w_tmoHit) begin
               w_curPriN   = INIT_PRI;
               w_initDoneN = 1'b1;
            end
         end
         S_IDLE: begin
            w_eoiPendN = 1'b0;
            if (w_eoiReq && r_depth != 4'd0) begin
               w_stateN    = S_EOI_WR;
               w_start     = 1'b1;
               w_startWe   = 1'b1;
               w_startAddr = 8'd1;
               w_startDat  = {5'd0, w_popVal};
            end else if (mask_req) begin
               w_stateN    = S_MASK_WR;
               w_start     = 1'b1;
               w_startWe   = 1'b1;
               w_startAddr = 8'd0;
               w_startDat  = mask_val;
            end else if (wb_irq && w_irqOk) begin
               w_stateN    = S_RD_IRQ;
               w_start     = 1'b1;
               w_startAddr = 8'd2;
            end
         end
         S_RD_IRQ: begin
            if (w_ack && wb_irq && (wb_dat_i[2:0] > r_curPri)) begin
               w_vecN   = wb_dat_i[2:0];
               w_afterN = S_WR_PRI;
            end
         end
         S_WR_PRI: begin
            if (w_ack) begin
`ifdef IRQ_NEST_EN
               w_push = 1'b1;
`endif
               w_curPriN = w_priVal;
               w_depthN  = r_depth + 4'd1;
               w_afterN  = S_DELIVER;
            end
         end
         S_DELIVER: begin
            if (vec_ready) w_stateN = S_IDLE;
         end
         S_EOI_WR: begin
            if (w_ack) begin
               w_curPriN = w_popVal;
               w_depthN  = r_depth - 4'd1;
            end
         end
         S_MASK_WR: begin
            if (w_ack) w_maskGntN = 1'b1;
         end
         S_GAP: begin
            w_stateN = r_after;
            if (r_after == S_INIT_PRI) begin
               w_start     = 1'b1;
               w_startWe   = 1'b1;
               w_startAddr = 8'd1;
               w_startDat  = {5'd0, INIT_PRI};
            end else if (r_after == S_WR_PRI) begin
               w_start     = 1'b1;
               w_startWe   = 1'b1;
               w_startAddr = 8'd1;
               w_startDat  = {5'd0, w_priVal};
            end
         end
         default: w_stateN = S_IDLE;
      endcase

      if (w_start) begin
         w_busN  = 1'b1;
         w_weN   = w_startWe;
         w_addrN = w_startAddr;
         w_datN  = w_startDat;
         w_tmoN  = 8'd0;
      end
   end

   assign wb_cyc_o  = r_bus;
   assign wb_stb_o  = r_bus;
   assign wb_sel_o  = r_bus;
   assign wb_we_o   = r_we;
   assign wb_addr_o = r_addr;
   assign wb_dat_o  = r_dat;
   assign vec_valid = (r_state == S_DELIVER);
   assign vec       = r_vec;
   assign mask_gnt  = r_maskGnt;
   assign depth     = r_depth;
   assign init_done = r_initDone;
   assign err       = r_err;

endmodule
